// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Load-stall FSM states.
    typedef enum logic [0:0] {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } hz_state_e;

    // Hard-wired zero register; a load targeting it never creates a hazard.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Control bundle driven towards the stall mux and the pipeline registers.
    typedef struct packed {
        logic mux_stall_sel;
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } ctrl_bundle_t;

    // Everything flows, ID control passes through.
    localparam ctrl_bundle_t CTRL_NORMAL = '{
        mux_stall_sel: 1'b1, pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
        id_ex_write: 1'b1, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0
    };

    // Load-use bubble: hold PC and IF/ID, zero the ID control, let EX/MEM drain.
    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        mux_stall_sel: 1'b0, pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b1, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0
    };

    // Taken branch: redirect the PC, squash the fetched and decoded instructions.
    localparam ctrl_bundle_t CTRL_FLUSH = '{
        mux_stall_sel: 1'b0, pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
        id_ex_write: 1'b1, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0
    };

    // Data memory busy: freeze every stage, feed a NOP into MEM/WB.
    localparam ctrl_bundle_t CTRL_FREEZE = '{
        mux_stall_sel: 1'b1, pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b0, ex_mem_write: 1'b0, mem_wb_bubble: 1'b1
    };

    // Safe bundle while the core is held in reset.
    localparam ctrl_bundle_t CTRL_RESET = '{
        mux_stall_sel: 1'b0, pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b0, ex_mem_write: 1'b0, mem_wb_bubble: 1'b1
    };

    // True when the load in EX writes a register the ID instruction reads.
    function automatic logic load_use_hit(
        input logic       ex_is_load,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_uses_rs1,
        input logic       id_uses_rs2
    );
        logic rs1_match;
        logic rs2_match;
        rs1_match = id_uses_rs1 & (ex_rd == id_rs1);
        rs2_match = id_uses_rs2 & (ex_rd == id_rs2);
        return ex_is_load & (ex_rd != REG_X0) & (rs1_match | rs2_match);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-controller bundle: pipeline hazard inputs and stage control outputs.
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             uses_rs1;
    logic             uses_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_mem_rd;
    logic             branch_taken;
    logic             ex_mem_req;
    logic             mem_ready;
    logic             mux_stall_sel;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             mem_wb_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;

    // Pipeline side: reports hazard conditions, consumes stage controls.
    modport master (
        output if_id_rs1, if_id_rs2, uses_rs1, uses_rs2, id_ex_rd, id_ex_mem_rd,
               branch_taken, ex_mem_req, mem_ready,
        input  mux_stall_sel, pc_write, if_id_write, if_id_flush, id_ex_write,
               ex_mem_write, mem_wb_bubble, stall_cycles, mem_timeout
    );

    // Hazard controller side.
    modport slave (
        input  if_id_rs1, if_id_rs2, uses_rs1, uses_rs2, id_ex_rd, id_ex_mem_rd,
               branch_taken, ex_mem_req, mem_ready,
        output mux_stall_sel, pc_write, if_id_write, if_id_flush, id_ex_write,
               ex_mem_write, mem_wb_bubble, stall_cycles, mem_timeout
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count up on enable, stick at all-ones, return to zero on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flush, memory-wait freeze,
// memory timeout monitor and stall-cycle statistics for the 5-stage core.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_USE_STALLS = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_ctrl_unit_if.slave hz
);
    localparam int               WAIT_W      = 16;
    localparam logic [2:0]       LD_RELOAD   = 3'(LOAD_USE_STALLS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = 16'(MEM_TIMEOUT - 1);
    localparam bit               MULTI_STALL = (LOAD_USE_STALLS > 1);

    hz_state_e         state_r;
    hz_state_e         state_nxt_s;
    logic [2:0]        ld_cnt_r;
    logic [2:0]        ld_cnt_nxt_s;
    ctrl_bundle_t      ctrl_s;
    ctrl_bundle_t      ctrl_out_s;
    logic              mem_wait_s;
    logic              lu_hit_s;
    logic              timeout_hit_s;
    logic              mem_timeout_r;
    logic              stall_en_s;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic [CNT_W-1:0]  stall_cnt_s;

    assign mem_wait_s = hz.ex_mem_req & ~hz.mem_ready;
    assign lu_hit_s   = load_use_hit(hz.id_ex_mem_rd, hz.id_ex_rd, hz.if_id_rs1,
                                     hz.if_id_rs2, hz.uses_rs1, hz.uses_rs2);

    // Prioritised control decode and load-stall next state:
    // memory wait, then branch, then an active load stall, then a new load-use hit.
    always_comb begin
        ctrl_s       = CTRL_NORMAL;
        state_nxt_s  = state_r;
        ld_cnt_nxt_s = ld_cnt_r;
        if (mem_wait_s) begin
            ctrl_s = CTRL_FREEZE;
        end else if (hz.branch_taken) begin
            ctrl_s       = CTRL_FLUSH;
            state_nxt_s  = RUN;
            ld_cnt_nxt_s = 3'd0;
        end else begin
            case (state_r)
                LOAD_STALL: begin
                    ctrl_s = CTRL_BUBBLE;
                    if (ld_cnt_r <= 3'd1) begin
                        state_nxt_s  = RUN;
                        ld_cnt_nxt_s = 3'd0;
                    end else begin
                        ld_cnt_nxt_s = ld_cnt_r - 3'd1;
                    end
                end
                RUN: begin
                    if (lu_hit_s) begin
                        ctrl_s = CTRL_BUBBLE;
                        if (MULTI_STALL) begin
                            state_nxt_s  = LOAD_STALL;
                            ld_cnt_nxt_s = LD_RELOAD;
                        end else begin
                            state_nxt_s  = RUN;
                            ld_cnt_nxt_s = 3'd0;
                        end
                    end else begin
                        ctrl_s = CTRL_NORMAL;
                    end
                end
                default: begin
                    ctrl_s       = CTRL_BUBBLE;
                    state_nxt_s  = RUN;
                    ld_cnt_nxt_s = 3'd0;
                end
            endcase
        end
    end

    // While reset is asserted the pipeline sees a frozen, bubbled bundle.
    always_comb begin
        if (!rst_n) begin
            ctrl_out_s = CTRL_RESET;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    // Load-stall FSM registers; reset aborts any pending stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RUN;
            ld_cnt_r <= 3'd0;
        end else begin
            state_r  <= state_nxt_s;
            ld_cnt_r <= ld_cnt_nxt_s;
        end
    end

    // Consecutive memory-wait cycles; any non-waiting cycle restarts the count.
    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~mem_wait_s),
        .en    (mem_wait_s),
        .count (wait_cnt_s)
    );

    // The timeout is reported in the very cycle the limit is reached, then held.
    assign timeout_hit_s = mem_wait_s & (wait_cnt_s >= WAIT_LIMIT);

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout_r <= 1'b0;
        end else if (timeout_hit_s) begin
            mem_timeout_r <= 1'b1;
        end else begin
            mem_timeout_r <= mem_timeout_r;
        end
    end

    // Every cycle the PC is held counts as a stall cycle.
    assign stall_en_s = ~ctrl_out_s.pc_write;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (stall_en_s),
        .count (stall_cnt_s)
    );

    assign hz.mux_stall_sel = ctrl_out_s.mux_stall_sel;
    assign hz.pc_write      = ctrl_out_s.pc_write;
    assign hz.if_id_write   = ctrl_out_s.if_id_write;
    assign hz.if_id_flush   = ctrl_out_s.if_id_flush;
    assign hz.id_ex_write   = ctrl_out_s.id_ex_write;
    assign hz.ex_mem_write  = ctrl_out_s.ex_mem_write;
    assign hz.mem_wb_bubble = ctrl_out_s.mem_wb_bubble;
    assign hz.stall_cycles  = stall_cnt_s;
    assign hz.mem_timeout   = rst_n & (mem_timeout_r | timeout_hit_s);

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core; it generates the select that the stall mux uses to zero ID-stage control signals (bubble insertion).
- Detects load-use hazards, applies taken-branch flushes and freezes the whole pipeline while data memory is not ready.
- Holds a small FSM for multi-cycle load stalls, a memory-wait timeout monitor and a saturating stall-cycle counter.

Parameters:
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..7).
MEM_TIMEOUT, 255, consecutive memory-wait cycles before mem_timeout sets (1..2^16-1).
CNT_W, 32, stall counter width.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
if_id_rs1  in  5  rs1 of instruction in ID.
if_id_rs2  in  5  rs2 of instruction in ID.
uses_rs1  in  1  ID instruction reads rs1.
uses_rs2  in  1  ID instruction reads rs2.
id_ex_rd  in  5  rd of instruction in EX.
id_ex_mem_rd  in  1  EX instruction is a load.
branch_taken  in  1  EX resolved taken branch/jump (PC_src != 0).
ex_mem_req  in  1  MEM stage Mem_rd or Mem_wr asserted.
mem_ready  in  1  data memory completes access this cycle.
mux_stall_sel  out  1  1 = pass ID control, 0 = bubble.
pc_write  out  1  PC register enable.
if_id_write  out  1  IF/ID enable.
if_id_flush  out  1  IF/ID clear to NOP.
id_ex_write  out  1  ID/EX enable.
ex_mem_write  out  1  EX/MEM enable.
mem_wb_bubble  out  1  load NOP into MEM/WB.
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.
mem_timeout  out  1  sticky memory-timeout error.

Behaviour:
- Reset: this is the only clock/reset scheme; reset is asynchronous and active-low on rst_n. While rst_n=0: state=RUN, ld_cnt=0, wait_cnt=0, stall_cycles=0, mem_timeout=0. Outputs forced to pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, mux_stall_sel=0, if_id_flush=0, mem_wb_bubble=1. Reset mid-stall aborts to RUN.
- Outputs are combinational from state and inputs. Zero added latency.
- Hazard terms:
  - mem_wait = ex_mem_req & ~mem_ready.
  - lu_hit = id_ex_mem_rd & (id_ex_rd!=0) & ((uses_rs1 & rd==rs1) | (uses_rs2 & rd==rs2)).
- Priority: mem_wait > branch_taken > LOAD_STALL state > lu_hit > normal.
- mem_wait (any state): all write enables=0, mem_wb_bubble=1, mux_stall_sel=1, if_id_flush=0. State and ld_cnt are held. wait_cnt increments (saturating). When wait_cnt reaches MEM_TIMEOUT-1 while still waiting, mem_timeout sets and stays set until reset. wait_cnt clears on any cycle without mem_wait.
- branch_taken (no mem_wait): pc_write=1, if_id_write=1, if_id_flush=1, mux_stall_sel=0, id_ex_write=1, ex_mem_write=1. Next state=RUN, ld_cnt=0. The branch cancels any pending load stall.
- RUN with lu_hit: pc_write=0, if_id_write=0, mux_stall_sel=0, other enables=1.
  - LOAD_USE_STALLS=1: stay RUN.
  - Otherwise: go to LOAD_STALL with ld_cnt=LOAD_USE_STALLS-1.
- LOAD_STALL: same outputs as lu_hit. ld_cnt decrements each cycle; at ld_cnt==1 the next state is RUN.
- Normal: all enables=1, mux_stall_sel=1, flush=0, mem_wb_bubble=0.
- stall_cycles: +1 on every cycle with pc_write=0 and rst_n=1. Saturates at 2^CNT_W-1; no wrap.

Decomposition:
- Shared package hazard_pkg:
  - state enum {RUN, LOAD_STALL}.
  - REG_X0 = 5'd0.
  - control-bundle struct matching the stall-mux fields.
- One natural sub-module: sat_counter (parameterised width, enable, saturate), used for stall_cycles and wait_cnt.

Test Plan:
- Reset with rst_n=0 mid-LOAD_STALL -> immediate outputs per reset list; after release, state=RUN and stall_cycles=0.
- Load x5 in EX, ID uses rs1=5 with uses_rs1=1 -> one cycle of mux_stall_sel=0, pc_write=0, if_id_write=0, then normal. stall_cycles=1. Same with id_ex_rd=0 or uses_rs1=0 -> no stall.
- LOAD_USE_STALLS=3, load-use hazard -> exactly 3 consecutive bubble cycles, stall_cycles=3.
- branch_taken=1 together with lu_hit -> if_id_flush=1, pc_write=1, mux_stall_sel=0, no stall next cycle. branch_taken during LOAD_STALL (ld_cnt=2) -> RUN next cycle.
- ex_mem_req=1, mem_ready=0 for 4 cycles during LOAD_STALL -> all enables=0, mem_wb_bubble=1, ld_cnt frozen. Stall resumes after mem_ready=1; stall_cycles counts all frozen cycles.
- MEM_TIMEOUT=8, mem_wait held 8 cycles -> mem_timeout=1 in cycle 8 and stays 1 after mem_ready returns, until rst_n=0.
